jtag_frame_assembler: RTL and testbench

//  Collects CHUNK_W-bit words written by the host over the virtual-JTAG bridge into one FRAME_W-bit frame.

---
 rtl/jtag_asm_pkg.sv | 18 +
 rtl/jtag_edge_sync.sv | 27 ++
 rtl/jtag_frame_assembler.sv | 149 ++++++++++++++
 tb/tb_jtag_frame_assembler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_asm_pkg.sv
// Shared types and geometry helpers for the JTAG frame assembler.
package jtag_asm_pkg;

  localparam int CHUNK_W_DEF    = 30;
  localparam int NUM_CHUNKS_DEF = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Counter width able to hold the value n itself (not just n-1).
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Synchronises an asynchronous host level and emits a one-cycle pulse on its rising edge.
// Latency: SYNC_STAGES cycles from the level change to the pulse; no backpressure.
module jtag_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/jtag_frame_assembler.sv
// Assembles host JTAG chunks into a frame held until the consumer acks; JTAG_ASM_PARITY_EN adds iPARITY/oPARITY_ERR.
// Latency iPROGRESS edge -> slot write SYNC_STAGES+1 cycles; no backpressure: surplus chunks or chunks during HOLD are dropped and flagged.
module jtag_frame_assembler
  import jtag_asm_pkg::*;
#(
  parameter  int CHUNK_W     = CHUNK_W_DEF,
  parameter  int NUM_CHUNKS  = NUM_CHUNKS_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int FRAME_W     = CHUNK_W * NUM_CHUNKS,
  localparam int IDX_W       = idx_w(NUM_CHUNKS)
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic [CHUNK_W-1:0] iDATA,
  input  logic               iPROGRESS,
  input  logic               iFRAME_END,
  input  logic               iFRAME_ACK,
`ifdef JTAG_ASM_PARITY_EN
  input  logic               iPARITY,
  output logic               oPARITY_ERR,
`endif
  output logic [FRAME_W-1:0] oFRAME,
  output logic               oFRAME_VALID,
  output logic [IDX_W-1:0]   oCHUNK_CNT,
  output logic               oBUSY,
  output logic               oOVERFLOW,
  output logic               oSHORT
);

  localparam logic [IDX_W-1:0] FULL = IDX_W'(NUM_CHUNKS);

  // Reset asserts asynchronously but is released in step with iCLK.
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic prg_pulse;
  logic end_pulse;

  jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_prg_sync (
    .clk      (iCLK),
    .rst_n    (rst_n),
    .async_in (iPROGRESS),
    .pulse    (prg_pulse)
  );

  jtag_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_end_sync (
    .clk      (iCLK),
    .rst_n    (rst_n),
    .async_in (iFRAME_END),
    .pulse    (end_pulse)
  );

  state_t state;
  state_t state_nxt;

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (prg_pulse)  state_nxt = FILL;
      FILL:    if (end_pulse)  state_nxt = HOLD;
      HOLD:    if (iFRAME_ACK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    oBUSY        = (state != IDLE);
    oFRAME_VALID = (state == HOLD);
  end

  logic [CHUNK_W-1:0] slot_q [NUM_CHUNKS];
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   cnt_nxt;
  logic               ovf_q;
  logic               short_q;
  logic               accept;
  logic               drop;
  logic               commit;
  logic               clear;

  // A commit in the same cycle as a chunk sees the count including that chunk.
  assign accept  = prg_pulse && (state != HOLD) && (cnt_q < FULL);
  assign drop    = prg_pulse && !accept;
  assign commit  = (state == FILL) && end_pulse;
  assign clear   = (state == HOLD) && iFRAME_ACK;
  assign cnt_nxt = cnt_q + IDX_W'(accept);

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHUNKS; k++) slot_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_CHUNKS; k++) slot_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        if (cnt_q == IDX_W'(k)) slot_q[k] <= iDATA;
      end
    end
  end

  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      if (drop)   ovf_q   <= 1'b1;
      if (commit) short_q <= (cnt_nxt < FULL);
    end
  end

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_frame
    assign oFRAME[k*CHUNK_W +: CHUNK_W] = slot_q[k];
  end

  assign oCHUNK_CNT = cnt_q;
  assign oOVERFLOW  = ovf_q;
  assign oSHORT     = short_q;

`ifdef JTAG_ASM_PARITY_EN
  logic perr_q;

  // Even parity over {iPARITY, iDATA}; the chunk is kept regardless.
  always_ff @(posedge iCLK or negedge rst_n) begin
    if (!rst_n)                             perr_q <= 1'b0;
    else if (clear)                         perr_q <= 1'b0;
    else if (prg_pulse && ^{iPARITY, iDATA}) perr_q <= 1'b1;
  end

  assign oPARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_jtag_frame_assembler.sv
// Randomised self-checking bench for jtag_frame_assembler against a slot-array reference model.
module tb_jtag_frame_assembler;

  localparam int CW = 30;
  localparam int NC = 27;
  localparam int SS = 2;
  localparam int FW = CW * NC;
  localparam int IW = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] data = '0;
  logic          progress = 1'b0;
  logic          fend = 1'b0;
  logic          ack = 1'b0;
  logic [FW-1:0] frame;
  logic          valid;
  logic [IW-1:0] cnt;
  logic          busy;
  logic          ovf;
  logic          shrt;
`ifdef JTAG_ASM_PARITY_EN
  logic          parity = 1'b0;
  logic          perr;
  bit            par_flip = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  // Reference model: frame contents as a slot array plus abstract status.
  logic [CW-1:0] m_slot [NC];
  int            m_cnt;
  bit            m_hold;
  bit            m_ovf;
  bit            m_short;
  bit            m_perr;

  jtag_frame_assembler dut (
    .iCLK         (clk),
    .iRESETn      (rst_n),
    .iDATA        (data),
    .iPROGRESS    (progress),
    .iFRAME_END   (fend),
    .iFRAME_ACK   (ack),
`ifdef JTAG_ASM_PARITY_EN
    .iPARITY      (parity),
    .oPARITY_ERR  (perr),
`endif
    .oFRAME       (frame),
    .oFRAME_VALID (valid),
    .oCHUNK_CNT   (cnt),
    .oBUSY        (busy),
    .oOVERFLOW    (ovf),
    .oSHORT       (shrt)
  );

  always #5 clk = ~clk;

  task automatic m_clear();
    for (int k = 0; k < NC; k++) m_slot[k] = '0;
    m_cnt = 0; m_hold = 0; m_ovf = 0; m_short = 0; m_perr = 0;
  endtask

  function automatic logic [FW-1:0] m_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NC; k++) f[k*CW +: CW] = m_slot[k];
    return f;
  endfunction

  task automatic m_chunk(input logic [CW-1:0] d);
    if (m_hold) m_ovf = 1;
    else if (m_cnt < NC) begin m_slot[m_cnt] = d; m_cnt++; end
    else m_ovf = 1;
  endtask

  task automatic m_end();
    if (!m_hold && m_cnt > 0) begin m_hold = 1; m_short = (m_cnt < NC); end
  endtask

  task automatic send_chunk(input logic [CW-1:0] d);
    data = d;
`ifdef JTAG_ASM_PARITY_EN
    parity = (^d) ^ par_flip;
    if (par_flip) m_perr = 1;
`endif
    repeat (SS + 2) @(negedge clk);
    progress = 1'b1;
    repeat (SS + 4) @(negedge clk);
    progress = 1'b0;
    repeat (SS + 2) @(negedge clk);
    m_chunk(d);
  endtask

  task automatic send_end();
    fend = 1'b1;
    repeat (SS + 4) @(negedge clk);
    fend = 1'b0;
    repeat (SS + 2) @(negedge clk);
    m_end();
  endtask

  task automatic send_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    if (m_hold) m_clear();
  endtask

  task automatic test_reset();
    vectors++; if (frame !== '0)   begin errors++; $display("FAIL rst_frame: got %h want 0", frame); end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    vectors++; if (cnt !== '0)     begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
    vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (ovf !== 1'b0)   begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    vectors++; if (shrt !== 1'b0)  begin errors++; $display("FAIL rst_short: got %b want 0", shrt); end
`ifdef JTAG_ASM_PARITY_EN
    vectors++; if (perr !== 1'b0)  begin errors++; $display("FAIL rst_perr: got %b want 0", perr); end
`endif
  endtask

  task automatic test_latency();
    logic [CW-1:0] d;
    d = CW'(32'h0ABC);
    data = d;
`ifdef JTAG_ASM_PARITY_EN
    parity = ^d;
`endif
    repeat (SS + 2) @(negedge clk);
    progress = 1'b1;
    repeat (SS) @(negedge clk);
    vectors++; if (cnt !== IW'(0)) begin errors++; $display("FAIL lat_early: cnt got %0d want 0", cnt); end
    @(negedge clk);
    vectors++; if (cnt !== IW'(1)) begin errors++; $display("FAIL lat_write: cnt got %0d want 1", cnt); end
    vectors++; if (frame[CW-1:0] !== d) begin errors++; $display("FAIL lat_slot0: got %h want %h", frame[CW-1:0], d); end
    progress = 1'b0;
    repeat (SS + 2) @(negedge clk);
    m_chunk(d);
    send_end();
    vectors++; if (shrt !== 1'b1) begin errors++; $display("FAIL lat_short: got %b want 1", shrt); end
    send_ack();
  endtask

  task automatic test_full();
    for (int k = 0; k < NC; k++) send_chunk(CW'(k + 1));
    send_end();
    vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", valid); end
    vectors++; if (frame[26*CW +: CW] !== CW'(27)) begin errors++; $display("FAIL full_slot26: got %h want %h", frame[26*CW +: CW], CW'(27)); end
    vectors++; if (shrt !== 1'b0) begin errors++; $display("FAIL full_short: got %b want 0", shrt); end
    vectors++; if (ovf !== 1'b0)  begin errors++; $display("FAIL full_ovf: got %b want 0", ovf); end
    vectors++; if (cnt !== IW'(27)) begin errors++; $display("FAIL full_cnt: got %0d want 27", cnt); end
    vectors++; if (frame !== m_frame()) begin errors++; $display("FAIL full_frame: got %h want %h", frame, m_frame()); end
    send_ack();
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL full_ack_valid: got %b want 0", valid); end
    vectors++; if (frame !== '0)   begin errors++; $display("FAIL full_ack_frame: got %h want 0", frame); end
  endtask

  task automatic test_short();
    for (int k = 0; k < 5; k++) send_chunk(CW'(32'h3FFF_FFFF));
    send_end();
    vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL short_valid: got %b want 1", valid); end
    vectors++; if (shrt !== 1'b1)  begin errors++; $display("FAIL short_flag: got %b want 1", shrt); end
    vectors++; if (frame[149:0] !== {150{1'b1}}) begin errors++; $display("FAIL short_low: got %h want all ones", frame[149:0]); end
    vectors++; if (frame[FW-1:150] !== '0) begin errors++; $display("FAIL short_high: got %h want 0", frame[FW-1:150]); end
    vectors++; if (cnt !== IW'(5)) begin errors++; $display("FAIL short_cnt: got %0d want 5", cnt); end
    send_ack();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < NC; k++) send_chunk(CW'($urandom));
    send_chunk(CW'(32'h1234));
    send_end();
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    vectors++; if (frame[26*CW +: CW] !== m_slot[26]) begin errors++; $display("FAIL ovf_slot26: got %h want %h", frame[26*CW +: CW], m_slot[26]); end
    vectors++; if (cnt !== IW'(NC)) begin errors++; $display("FAIL ovf_cnt: got %0d want %0d", cnt, NC); end
    vectors++; if (frame !== m_frame()) begin errors++; $display("FAIL ovf_frame: got %h want %h", frame, m_frame()); end
    send_ack();
    vectors++; if ({valid, busy, ovf, shrt} !== 4'b0) begin errors++; $display("FAIL ovf_ack_flags: got %b want 0000", {valid, busy, ovf, shrt}); end
    vectors++; if (cnt !== '0) begin errors++; $display("FAIL ovf_ack_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 3; k++) send_chunk(CW'($urandom));
    send_end();
    send_chunk(CW'(32'h5555));
    send_end();
    vectors++; if (frame !== m_frame()) begin errors++; $display("FAIL hold_frame: got %h want %h", frame, m_frame()); end
    vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL hold_ovf: got %b want 1", ovf); end
    vectors++; if (cnt !== IW'(3)) begin errors++; $display("FAIL hold_cnt: got %0d want 3", cnt); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_ack_valid: got %b want 0", valid); end
    m_clear();
    @(negedge clk);
    vectors++; if (frame !== '0) begin errors++; $display("FAIL hold_ack_frame: got %h want 0", frame); end
  endtask

  task automatic test_idle_events();
    send_end();
    vectors++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL idle_end: valid/busy got %b want 00", {valid, busy}); end
    send_chunk(CW'($urandom));
    send_chunk(CW'($urandom));
    send_ack();
    vectors++; if (cnt !== IW'(2) || busy !== 1'b1) begin errors++; $display("FAIL fill_ack: cnt %0d busy %b want 2 1", cnt, busy); end
    // Chunk and commit edges arrive together: chunk lands first, then the commit.
    data = CW'($urandom);
`ifdef JTAG_ASM_PARITY_EN
    parity = ^data;
`endif
    repeat (SS + 2) @(negedge clk);
    progress = 1'b1; fend = 1'b1;
    repeat (SS + 4) @(negedge clk);
    progress = 1'b0; fend = 1'b0;
    repeat (SS + 2) @(negedge clk);
    m_chunk(data); m_end();
    vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b want 1", valid); end
    vectors++; if (cnt !== IW'(3)) begin errors++; $display("FAIL same_cnt: got %0d want 3", cnt); end
    vectors++; if (frame !== m_frame()) begin errors++; $display("FAIL same_frame: got %h want %h", frame, m_frame()); end
    send_ack();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10; k++) send_chunk(CW'($urandom));
    vectors++; if (cnt !== IW'(10)) begin errors++; $display("FAIL rmid_pre_cnt: got %0d want 10", cnt); end
    rst_n = 1'b0;
    #1;
    m_clear();
    vectors++; if ({valid, busy, ovf, shrt} !== 4'b0) begin errors++; $display("FAIL rmid_flags: got %b want 0000", {valid, busy, ovf, shrt}); end
    vectors++; if (cnt !== '0 || frame !== '0) begin errors++; $display("FAIL rmid_data: cnt %0d frame nonzero %b want 0 0", cnt, |frame); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_novalid: got %b want 0", valid); end
    send_chunk(CW'($urandom));
    send_chunk(CW'($urandom));
    send_end();
    vectors++; if (frame[CW-1:0] !== m_slot[0]) begin errors++; $display("FAIL rmid_slot0: got %h want %h", frame[CW-1:0], m_slot[0]); end
    vectors++; if (frame !== m_frame() || cnt !== IW'(2)) begin errors++; $display("FAIL rmid_frame: cnt got %0d want 2, frame eq %b", cnt, frame === m_frame()); end
    send_ack();
  endtask

`ifdef JTAG_ASM_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b1;
    send_chunk(CW'(1));
    par_flip = 1'b0;
    vectors++; if (perr !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", perr); end
    vectors++; if (frame[CW-1:0] !== CW'(1)) begin errors++; $display("FAIL par_slot0: got %h want 1", frame[CW-1:0]); end
    send_end();
    send_ack();
    vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", perr); end
    send_chunk(CW'(1));
    vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL par_ok: got %b want 0", perr); end
    send_end();
    send_ack();
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, NC + 3);
      for (int k = 0; k < n; k++) begin
`ifdef JTAG_ASM_PARITY_EN
        par_flip = ($urandom_range(0, 7) == 0);
`endif
        send_chunk(CW'($urandom));
      end
`ifdef JTAG_ASM_PARITY_EN
      par_flip = 1'b0;
`endif
      send_end();
      vectors++; if (cnt !== IW'(m_cnt)) begin errors++; $display("FAIL rnd%0d_cnt: got %0d want %0d", it, cnt, m_cnt); end
      vectors++; if ({valid, ovf, shrt} !== {m_hold, m_ovf, m_short}) begin errors++; $display("FAIL rnd%0d_flags: got %b want %b", it, {valid, ovf, shrt}, {m_hold, m_ovf, m_short}); end
      vectors++; if (frame !== m_frame()) begin errors++; $display("FAIL rnd%0d_frame: got %h want %h", it, frame, m_frame()); end
`ifdef JTAG_ASM_PARITY_EN
      vectors++; if (perr !== m_perr) begin errors++; $display("FAIL rnd%0d_perr: got %b want %b", it, perr, m_perr); end
`endif
      send_ack();
      vectors++; if ({valid, busy} !== 2'b00 || cnt !== '0) begin errors++; $display("FAIL rnd%0d_ack: valid/busy %b cnt %0d want 00 0", it, {valid, busy}, cnt); end
    end
  endtask

  initial begin
    m_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_latency();
    test_full();
    test_short();
    test_overflow();
    test_hold();
    test_idle_events();
    test_reset_mid();
`ifdef JTAG_ASM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
